// File: rtl/noc_pkg.sv
// Shared NoC types: the flit width default, the VC identifier type and the FIFO helpers.
package noc_pkg;

  localparam int unsigned NOC_FLIT_WIDTH = 512;
  localparam int unsigned NOC_VC_ID_W    = 8;

  typedef logic [NOC_VC_ID_W-1:0] vc_id_t;

  // Encoded as {push, pop} so a controller can cast its two strobes directly.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic int unsigned flat_addr(input int unsigned vc, input int unsigned ptr,
                                            input int unsigned depth);
    return vc * depth + ptr;
  endfunction

endpackage

// File: rtl/fifo_nvc_if.sv
// Handshake and status bundle between a multi-VC FIFO and its user.
interface fifo_nvc_if #(
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 512
);

  logic [WIDTH-1:0]              data;
  logic [$clog2(NUM_VC)-1:0]     wrvc;
  logic                          wrreq;
  logic [NUM_VC-1:0]             rdreq;
  logic [WIDTH-1:0]              q           [NUM_VC];
  logic [NUM_VC-1:0]             empty;
  logic [NUM_VC-1:0]             full;
  logic [NUM_VC-1:0]             almost_full;
  logic [$clog2(DEPTH+1)-1:0]    usedw       [NUM_VC];
  logic                          overflow;
  logic                          underflow;

  modport master (
    output data, wrvc, wrreq, rdreq,
    input  q, empty, full, almost_full, usedw, overflow, underflow
  );

  modport slave (
    input  data, wrvc, wrreq, rdreq,
    output q, empty, full, almost_full, usedw, overflow, underflow
  );

endinterface

// File: rtl/fifo_nvc_ctrl.sv
// Per-VC pointer/counter controller; status flags are registered from the next-state count.
module fifo_nvc_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       sclr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic                       push,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] usedw,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] usedw_q, usedw_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             pop;
  fifo_op_e         op;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A write to a full VC is dropped even when the same cycle pops it.
  assign push = wr_en && !full_q && !sclr;
  assign pop  = rd_en && !empty_q && !sclr;
  assign op   = fifo_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    case (op)
      OpPush: begin
        wr_ptr_d = ptr_next(wr_ptr_q);
        usedw_d  = usedw_q + CNT_W'(1);
      end
      OpPop: begin
        rd_ptr_d = ptr_next(rd_ptr_q);
        usedw_d  = usedw_q - CNT_W'(1);
      end
      OpBoth: begin
        wr_ptr_d = ptr_next(wr_ptr_q);
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      default: ;
    endcase
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end
    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == CNT_W'(DEPTH));
    af_d    = (32'(usedw_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
    end
  end

  assign wr_ptr      = wr_ptr_q;
  assign rd_ptr      = rd_ptr_q;
  assign usedw       = usedw_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;

endmodule

// File: rtl/fifo_nvc.sv
// Multi-VC FIFO: one shared flit array, each VC owning a private DEPTH-entry region.
module fifo_nvc
  import noc_pkg::*;
#(
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = NOC_FLIT_WIDTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input logic       clk,
  input logic       aclr,
  input logic       sclr,
  fifo_nvc_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned ADDR_W = $clog2(NUM_VC * DEPTH);

  logic [WIDTH-1:0]  mem [NUM_VC * DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [NUM_VC-1:0] wr_sel;
  logic [NUM_VC-1:0] push;
  logic [ADDR_W-1:0] waddr;
  vc_id_t            wrvc_ext;
  logic              wrvc_ok;
  logic              ovf_set, udf_set;
  logic              ovf_q, udf_q;

  assign wrvc_ext = vc_id_t'(bus.wrvc);
  assign wrvc_ok  = (wrvc_ext < vc_id_t'(NUM_VC));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_sel[v] = bus.wrreq && wrvc_ok && (wrvc_ext == vc_id_t'(v));

    fifo_nvc_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
    ) u_ctrl (
      .clk         (clk),
      .aclr        (aclr),
      .sclr        (sclr),
      .wr_en       (wr_sel[v]),
      .rd_en       (bus.rdreq[v]),
      .push        (push[v]),
      .wr_ptr      (wr_ptr[v]),
      .rd_ptr      (rd_ptr[v]),
      .usedw       (bus.usedw[v]),
      .empty       (bus.empty[v]),
      .full        (bus.full[v]),
      .almost_full (bus.almost_full[v])
    );

    // Show-ahead head flit; stale contents when the VC is empty.
    assign bus.q[v] = mem[ADDR_W'(flat_addr(v, 32'(rd_ptr[v]), DEPTH))];
  end

  always_comb begin
    waddr = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_sel[v]) waddr = ADDR_W'(flat_addr(v, 32'(wr_ptr[v]), DEPTH));
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (|push) mem[waddr] <= bus.data;
  end

  assign ovf_set = bus.wrreq && (!wrvc_ok || |(wr_sel & bus.full));
  assign udf_set = |(bus.rdreq & bus.empty);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (sclr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_fifo_nvc.sv
// Directed bench for fifo_nvc with NUM_VC=4, DEPTH=4, WIDTH=8, AF_LEVEL=3.
module tb_fifo_nvc;

  logic clk = 1'b0;
  logic aclr;
  logic sclr;
  int   total = 0;
  int   bad   = 0;

  fifo_nvc_if #(.NUM_VC(4), .DEPTH(4), .WIDTH(8)) bus ();

  fifo_nvc #(
    .NUM_VC   (4),
    .DEPTH    (4),
    .WIDTH    (8),
    .AF_LEVEL (3)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .sclr (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wrreq = 1'b0;
    bus.rdreq = '0;
    sclr      = 1'b0;
  endtask

  task automatic clear();
    idle();
    sclr = 1'b1;
    cycle();
    sclr = 1'b0;
  endtask

  task automatic write(input logic [1:0] vc, input logic [7:0] d);
    bus.wrreq = 1'b1;
    bus.wrvc  = vc;
    bus.data  = d;
    cycle();
    bus.wrreq = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    idle();
    bus.data = '0;
    bus.wrvc = '0;
    #2;
    total++;
    if (bus.empty !== 4'b1111) begin
      bad++; $display("FAIL reset_empty got %b want 1111", bus.empty);
    end
    total++;
    if (bus.full !== 4'b0000 || bus.almost_full !== 4'b0000) begin
      bad++; $display("FAIL reset_full_af got %b/%b want 0000/0000", bus.full, bus.almost_full);
    end
    total++;
    if (bus.usedw[0] !== 3'd0 || bus.usedw[3] !== 3'd0) begin
      bad++; $display("FAIL reset_usedw got %0d/%0d want 0/0", bus.usedw[0], bus.usedw[3]);
    end
    total++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got %b/%b want 0/0", bus.overflow, bus.underflow);
    end
    cycle();
    aclr = 1'b0;
    cycle();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) write(2'd2, 8'h10 + 8'(i));
    total++;
    if (bus.full[2] !== 1'b1 || bus.usedw[2] !== 3'd4) begin
      bad++; $display("FAIL fill_full got full=%b usedw=%0d want 1/4", bus.full[2], bus.usedw[2]);
    end
    write(2'd2, 8'h14);
    total++;
    if (bus.overflow !== 1'b1 || bus.usedw[2] !== 3'd4) begin
      bad++; $display("FAIL fill_ovf got ovf=%b usedw=%0d want 1/4", bus.overflow, bus.usedw[2]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.q[2] !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL drain_q%0d got %h want %h", i, bus.q[2], 8'h10 + 8'(i));
      end
      bus.rdreq = 4'b0100;
      cycle();
    end
    bus.rdreq = '0;
    total++;
    if (bus.empty[2] !== 1'b1 || bus.underflow !== 1'b0) begin
      bad++; $display("FAIL drain_empty got empty=%b udf=%b want 1/0", bus.empty[2], bus.underflow);
    end
  endtask

  task automatic test_sclr();
    write(2'd1, 8'h99);
    bus.wrreq = 1'b1;
    bus.wrvc  = 2'd0;
    bus.data  = 8'h55;
    bus.rdreq = 4'b0010;
    sclr      = 1'b1;
    cycle();
    idle();
    total++;
    if (bus.overflow !== 1'b0 || bus.empty !== 4'b1111 || bus.usedw[0] !== 3'd0) begin
      bad++; $display("FAIL sclr got ovf=%b empty=%b usedw0=%0d want 0/1111/0",
                      bus.overflow, bus.empty, bus.usedw[0]);
    end
  endtask

  task automatic test_isolation();
    write(2'd0, 8'hA0);
    write(2'd3, 8'hB0);
    write(2'd0, 8'hA1);
    total++;
    if (bus.q[0] !== 8'hA0 || bus.q[3] !== 8'hB0) begin
      bad++; $display("FAIL iso_q got %h/%h want a0/b0", bus.q[0], bus.q[3]);
    end
    total++;
    if (bus.empty !== 4'b0110 || bus.usedw[0] !== 3'd2 || bus.usedw[3] !== 3'd1) begin
      bad++; $display("FAIL iso_state got empty=%b u0=%0d u3=%0d want 0110/2/1",
                      bus.empty, bus.usedw[0], bus.usedw[3]);
    end
    clear();
  endtask

  task automatic test_simultaneous();
    logic [7:0] model [$];
    logic [7:0] d;
    write(2'd1, 8'h50);
    write(2'd1, 8'h51);
    model.push_back(8'h50);
    model.push_back(8'h51);
    for (int i = 0; i < 10; i++) begin
      d = 8'h60 + 8'(i);
      total++;
      if (bus.q[1] !== model[0]) begin
        bad++; $display("FAIL simul_q%0d got %h want %h", i, bus.q[1], model[0]);
      end
      bus.wrreq = 1'b1;
      bus.wrvc  = 2'd1;
      bus.data  = d;
      bus.rdreq = 4'b0010;
      cycle();
      void'(model.pop_front());
      model.push_back(d);
      total++;
      if (bus.usedw[1] !== 3'd2) begin
        bad++; $display("FAIL simul_usedw%0d got %0d want 2", i, bus.usedw[1]);
      end
    end
    idle();
    total++;
    if (bus.q[1] !== 8'h68) begin
      bad++; $display("FAIL simul_tail got %h want 68", bus.q[1]);
    end
    clear();
  endtask

  task automatic test_empty_read();
    bus.rdreq = 4'b0001;
    write(2'd0, 8'h77);
    bus.rdreq = '0;
    total++;
    if (bus.underflow !== 1'b1 || bus.usedw[0] !== 3'd1) begin
      bad++; $display("FAIL udf got udf=%b usedw=%0d want 1/1", bus.underflow, bus.usedw[0]);
    end
    total++;
    if (bus.q[0] !== 8'h77 || bus.empty[0] !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL udf_q got q=%h empty=%b ovf=%b want 77/0/0",
                      bus.q[0], bus.empty[0], bus.overflow);
    end
    clear();
  endtask

  task automatic test_back_to_back();
    write(2'd0, 8'h01);
    write(2'd1, 8'h02);
    write(2'd3, 8'h03);
    bus.rdreq = 4'b1011;
    write(2'd2, 8'h44);
    bus.rdreq = '0;
    total++;
    if (bus.empty !== 4'b1011 || bus.usedw[2] !== 3'd1 || bus.q[2] !== 8'h44) begin
      bad++; $display("FAIL concurrent got empty=%b u2=%0d q2=%h want 1011/1/44",
                      bus.empty, bus.usedw[2], bus.q[2]);
    end
    total++;
    if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL concurrent_flags got %b/%b want 0/0", bus.overflow, bus.underflow);
    end
    clear();
  endtask

  task automatic test_almost_full();
    write(2'd2, 8'hC0);
    write(2'd2, 8'hC1);
    total++;
    if (bus.almost_full[2] !== 1'b0) begin
      bad++; $display("FAIL af_two got %b want 0", bus.almost_full[2]);
    end
    write(2'd2, 8'hC2);
    total++;
    if (bus.almost_full[2] !== 1'b1 || bus.full[2] !== 1'b0 || bus.usedw[2] !== 3'd3) begin
      bad++; $display("FAIL af_three got af=%b full=%b usedw=%0d want 1/0/3",
                      bus.almost_full[2], bus.full[2], bus.usedw[2]);
    end
  endtask

  task automatic test_async_reset();
    // Three entries from the almost-full test are still queued on VC2.
    #3 aclr = 1'b1;
    #1;
    total++;
    if (bus.empty[2] !== 1'b1 || bus.usedw[2] !== 3'd0 || bus.almost_full[2] !== 1'b0) begin
      bad++; $display("FAIL aclr got empty=%b usedw=%0d af=%b want 1/0/0",
                      bus.empty[2], bus.usedw[2], bus.almost_full[2]);
    end
    #1 aclr = 1'b0;
    cycle();
    write(2'd2, 8'hD5);
    total++;
    if (bus.q[2] !== 8'hD5 || bus.usedw[2] !== 3'd1) begin
      bad++; $display("FAIL aclr_after got q=%h usedw=%0d want d5/1", bus.q[2], bus.usedw[2]);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_sclr();
    test_isolation();
    test_simultaneous();
    test_empty_read();
    test_back_to_back();
    test_almost_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_nvc.md
FIFO_NVC -- requirements
Module: fifo_nvc

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, the number of virtual channels (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, the entries per VC (>=2; power of two not required).
REQ-003 SHALL have parameter WIDTH, default 512, the flit width in bits.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1, the occupancy at or above which almost_full asserts.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port aclr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port sclr, input, 1 bit: synchronous clear of all VCs, active-high.
REQ-008 SHALL have port data, input, WIDTH bits: write flit.
REQ-009 SHALL have port wrvc, input, clog2(NUM_VC) bits: target VC of the write.
REQ-010 SHALL have port wrreq, input, 1 bit: write strobe; at most one VC is written per cycle.
REQ-011 SHALL have port rdreq[NUM_VC], input, 1 bit each: per-VC pop strobe.
REQ-012 SHALL have port q[NUM_VC], output, WIDTH bits each: per-VC head flit, show-ahead.
REQ-013 SHALL have port empty[NUM_VC], output, 1 bit each: VC holds 0 entries.
REQ-014 SHALL have port full[NUM_VC], output, 1 bit each: VC holds DEPTH entries.
REQ-015 SHALL have port almost_full[NUM_VC], output, 1 bit each: occupancy >= AF_LEVEL.
REQ-016 SHALL have port usedw[NUM_VC], output, clog2(DEPTH+1) bits each: VC occupancy.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag for a write to a full VC.
REQ-018 SHALL have port underflow, output, 1 bit: sticky flag for a read of an empty VC.

Function
REQ-019 SHALL hold NUM_VC*DEPTH entries in one register array, each VC owning a private DEPTH-entry region addressed {vc, ptr}.
REQ-020 SHALL keep per VC a write pointer, a read pointer and a counter; each pointer wraps from DEPTH-1 to 0.
REQ-021 SHALL, on wrreq with VC wrvc not full, store data at that VC's write pointer, advance the pointer, and increment usedw.
REQ-022 SHALL, on rdreq[v] with VC v not empty, advance that VC's read pointer and decrement usedw.
REQ-023 SHALL, on a simultaneous valid write and read to the same VC, leave usedw unchanged and move both pointers.
REQ-024 SHALL, when a write targets a full VC, drop the write, leave all state unchanged, and set overflow, even if the same cycle has rdreq on that VC.
REQ-025 SHALL, when a read targets an empty VC, ignore the read and set underflow, even if the same cycle writes that VC.
REQ-026 SHALL present q[v] combinationally from the read pointer of VC v; q[v] is valid whenever empty[v]=0.
REQ-027 SHALL give write-to-q latency of 1 cycle: a flit written at edge N is visible on q and empty deasserted after edge N.
REQ-028 SHALL derive empty, full and almost_full as registered-counter compares, updated in the same cycle as usedw.
REQ-029 SHALL treat independent VCs as fully concurrent: reads on all VCs and one write in the same cycle are all honoured.
REQ-030 SHALL clear overflow and underflow only by reset or sclr.
REQ-031 SHALL treat an out-of-range wrvc (>=NUM_VC) as a dropped write that sets overflow.

Reset
REQ-032 SHALL, on aclr=1, immediately zero all pointers, usedw, overflow and underflow; afterwards empty=1, full=0, almost_full=0 (AF_LEVEL>0), and q is don't-care.
REQ-033 SHALL, on sclr=1 at an edge, produce the same state as aclr and ignore any same-cycle wrreq or rdreq.
REQ-034 SHALL not reset the storage array.
REQ-035 SHALL, when aclr asserts mid-transfer, discard all stored flits.

Structure
REQ-036 SHALL take vc_id_t and the flit width default from the shared noc_pkg.
REQ-037 SHALL implement per-VC pointer and counter logic as sub-module fifo_nvc_ctrl, instantiated NUM_VC times.

Verification
REQ-038 SHALL cover the fill/drain test (NUM_VC=4, DEPTH=4, WIDTH=8): write 0x10..0x13 to VC2 -> full[2]=1 and usedw[2]=4; 5th write 0x14 -> dropped and overflow=1; 4 reads return 0x10..0x13.
REQ-039 SHALL cover VC isolation: interleave writes to VC0 (0xA0, 0xA1) and VC3 (0xB0) -> q[0]=0xA0, q[3]=0xB0, empty[1]=empty[2]=1.
REQ-040 SHALL cover simultaneous access: VC1 holds 2 entries, then wrreq and rdreq on VC1 for 10 cycles -> usedw[1] stays 2 and FIFO order holds across pointer wrap.
REQ-041 SHALL cover read of an empty VC: rdreq[0] on empty VC0 together with a write to VC0 -> underflow=1, usedw[0]=1, q[0]=written data next cycle.
REQ-042 SHALL cover async reset: assert aclr between edges with 3 entries queued -> empty=1 and usedw=0 before the next edge.
REQ-043 SHALL cover almost_full (AF_LEVEL=3): 3 writes to VC2 -> almost_full[2]=1 with full[2]=0.
